dmem_hs: RTL and testbench

DMEM_HS -- requirements
Module: dmem_hs

---
 rtl/dmem_hs.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_hs.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_hs.sv
// ---------------------------------------------------------------------------
// dmem_hs - handshaked single-port data memory with byte/half/word access
//
// Accepts one load or store at a time through a req/ready handshake. After
// acceptance it waits LATENCY cycles, then completes in a single RESP cycle
// that carries o_done_w, o_err_w and (for loads) the extended read data.
// Lanes are little-endian. Misaligned, reserved-size or out-of-range
// accesses fault and leave memory untouched.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, 4..4096)
//   LATENCY      wait cycles per access (0..7)
//
// Ports
//   i_clk_w       clock, rising edge
//   i_rst_w       asynchronous active-high reset (memory array not cleared)
//   i_req_w       access request, sampled only in IDLE
//   o_ready_w     high in IDLE, request will be accepted on the next edge
//   i_we_w        1 = store, 0 = load
//   i_size_w      00 byte, 01 half, 10 word, 11 reserved (faults)
//   i_unsigned_w  1 = zero-extend loads, 0 = sign-extend
//   i_a_w         byte address
//   i_wd_w        store data, right-justified
//   o_rd_w        load data; zero outside RESP and for stores/faults
//   o_done_w      one-cycle completion pulse
//   o_err_w       fault flag, qualified by o_done_w
// ---------------------------------------------------------------------------
module dmem_hs #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 1
) (
    input  logic        i_clk_w,
    input  logic        i_rst_w,
    input  logic        i_req_w,
    output logic        o_ready_w,
    input  logic        i_we_w,
    input  logic [1:0]  i_size_w,
    input  logic        i_unsigned_w,
    input  logic [31:0] i_a_w,
    input  logic [31:0] i_wd_w,
    output logic [31:0] o_rd_w,
    output logic        o_done_w,
    output logic        o_err_w
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter preload: WAIT lasts WAIT_INIT+1 cycles.
    localparam logic [2:0] WAIT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        enter_resp;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;

    logic [31:0] rd_q;
    logic        err_q;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic [31:0] acc_a;
    logic [31:0] acc_wd;

    logic          fault;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   word_rd;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic          do_write;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=0 the access enters RESP on its accept edge, so the
    // commit must use the live inputs; otherwise it uses the captured copy.
    always_comb begin
        if (state == S_IDLE) begin
            acc_we   = i_we_w;
            acc_size = i_size_w;
            acc_uns  = i_unsigned_w;
            acc_a    = i_a_w;
            acc_wd   = i_wd_w;
        end else begin
            acc_we   = we_q;
            acc_size = size_q;
            acc_uns  = uns_q;
            acc_a    = a_q;
            acc_wd   = wd_q;
        end
    end

    // Next-state logic; enter_resp marks the edge that commits the access.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        o_ready_w  = 1'b0;
        o_done_w   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready_w = 1'b1;
                if (i_req_w) begin
                    if (LATENCY == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            S_RESP: begin
                o_done_w  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Fault detection; with a power-of-2 depth, a[31:2] >= DEPTH_WORDS
    // reduces to any address bit above the word index being set.
    always_comb begin
        idx = acc_a[AW+1:2];
        off = acc_a[1:0];
        case (acc_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = acc_a[0];
            2'b10:   fault = (acc_a[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
        if (|acc_a[31:AW+2]) begin
            fault = 1'b1;
        end
    end

    // Lane enables and replicated write data so each lane sees its slice.
    always_comb begin
        case (acc_size)
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{acc_wd[7:0]}};
            end
            2'b01: begin
                be    = acc_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{acc_wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = acc_wd;
            end
        endcase
    end

    // Load path: right-justify the addressed lanes, then extend.
    always_comb begin
        word_rd = mem[idx];
        shifted = word_rd >> {off, 3'b000};
        case (acc_size)
            2'b00:   load_val = acc_uns ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = acc_uns ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = word_rd;
        endcase
    end

    // Gated by reset so a zero-latency accept cannot write while resetting.
    assign do_write = enter_resp & acc_we & ~fault & ~i_rst_w;

    // Memory array has no reset; its contents survive i_rst_w.
    always_ff @(posedge i_clk_w) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // State, captured request and response registers. rd/err are only
    // loaded on the edge into RESP and cleared on every other edge, so they
    // read as zero outside RESP.
    always_ff @(posedge i_clk_w or posedge i_rst_w) begin
        if (i_rst_w) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            we_q   <= 1'b0;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
            a_q    <= 32'd0;
            wd_q   <= 32'd0;
            rd_q   <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && i_req_w) begin
                we_q   <= i_we_w;
                size_q <= i_size_w;
                uns_q  <= i_unsigned_w;
                a_q    <= i_a_w;
                wd_q   <= i_wd_w;
            end
            if (enter_resp) begin
                err_q <= fault;
                rd_q  <= (fault || acc_we) ? 32'd0 : load_val;
            end else begin
                err_q <= 1'b0;
                rd_q  <= 32'd0;
            end
        end
    end

    assign o_rd_w  = rd_q;
    assign o_err_w = err_q;

endmodule

// File: tb/tb_dmem_hs.sv
// ---------------------------------------------------------------------------
// tb_dmem_hs - directed self-checking bench for dmem_hs
// (DEPTH_WORDS=64, LATENCY=2). Inputs change on the falling edge; outputs
// are sampled 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_hs;

    logic        clk;
    logic        rst;
    logic        req;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done;
    logic        err;

    int vectors = 0;
    int errors  = 0;

    dmem_hs #(
        .DEPTH_WORDS(64),
        .LATENCY    (2)
    ) dut (
        .i_clk_w     (clk),
        .i_rst_w     (rst),
        .i_req_w     (req),
        .o_ready_w   (ready),
        .i_we_w      (we),
        .i_size_w    (size),
        .i_unsigned_w(uns),
        .i_a_w       (addr),
        .i_wd_w      (wd),
        .o_rd_w      (rd),
        .o_done_w    (done),
        .o_err_w     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access from IDLE. The done pulse is expected to appear
    // after the third rising edge, counting the accept edge as the first
    // (accept edge, one WAIT edge, then the edge into RESP).
    task automatic applyStimulus(input string tag, input logic s_we,
                                 input logic [1:0] s_size, input logic s_uns,
                                 input logic [31:0] s_a, input logic [31:0] s_wd,
                                 input logic [31:0] exp_rd, input logic exp_err);
        int edges;
        @(negedge clk);
        req  = 1'b1;
        we   = s_we;
        size = s_size;
        uns  = s_uns;
        addr = s_a;
        wd   = s_wd;
        @(posedge clk);
        #1;
        req  = 1'b0;
        // Scramble the inputs after acceptance; the DUT must ignore them.
        we   = ~s_we;
        size = ~s_size;
        uns  = ~s_uns;
        addr = ~s_a;
        wd   = ~s_wd;
        checkOutput({tag, "_busy"}, {31'd0, ready}, 32'd0);
        edges = 1;
        while (!done && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_lat"}, edges, 32'd3);
        checkOutput({tag, "_rd"}, rd, exp_rd);
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, {29'd0, ready, done, err}, 32'b100);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        we   = 1'b0;
        size = 2'b00;
        uns  = 1'b0;
        addr = 32'd0;
        wd   = 32'd0;
        #1;
        checkOutput("por_flags", {29'd0, ready, done, err}, 32'b100);
        checkOutput("por_rd", rd, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        applyStimulus("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Sub-word loads and a byte store
        applyStimulus("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        applyStimulus("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        applyStimulus("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        applyStimulus("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        applyStimulus("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, 32'h0, 1'b0);
        applyStimulus("lw10b", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);

        // Faulting accesses leave memory untouched
        applyStimulus("sh11",  1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus("sw12",  1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus("sz11",  1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus("lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        applyStimulus("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);

        // Asynchronous reset in RESP with load data on the bus
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        size = 2'b10;
        addr = 32'h10;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rresp_done", {31'd0, done}, 32'd1);
        checkOutput("rresp_rd", rd, 32'hDEAD7FEF);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_flags", {29'd0, ready, done, err}, 32'b100);
        checkOutput("arst_rd", rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("arst_after", {29'd0, ready, done, err}, 32'b100);

        // Reset during WAIT abandons an uncommitted store
        applyStimulus("sw20z", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b1;
        size = 2'b10;
        addr = 32'h20;
        wd   = 32'h12345678;
        @(posedge clk);
        #1;
        req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("wrst_flags", {29'd0, ready, done, err}, 32'b100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("wrst_nodone", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Request held for 20 cycles: accepts on edges 0,4,8,12,16 (store,
        // load, store, load, store), done on edges 2,6,10,14,18. Store data
        // is 0xC0DE0000 plus the cycle index, so the loads return the data of
        // the stores accepted on edges 0 and 8.
        begin
            int pulses;
            logic [31:0] exp_rd;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                req  = 1'b1;
                we   = ~i[2];
                size = 2'b10;
                uns  = 1'b0;
                addr = 32'h30;
                wd   = 32'hC0DE0000 + i;
                @(posedge clk);
                #1;
                if (done) pulses++;
                checkOutput($sformatf("bb_done%0d", i), {31'd0, done},
                            {31'd0, (i % 4) == 2});
                exp_rd = (i == 6) ? 32'hC0DE0000 : (i == 14) ? 32'hC0DE0008 : 32'h0;
                checkOutput($sformatf("bb_rd%0d", i), rd, exp_rd);
            end
            @(negedge clk);
            req = 1'b0;
            checkOutput("bb_pulses", pulses, 32'd5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
